// File: rtl/dmem_mmio_responder_if.sv
// Processor data port, dmem port and output-FIFO stream bundled for the MMIO responder.
// Stream handshake: out_data/out_valid are stable registered state; a word transfers on a rising edge where out_valid && out_ready.
interface dmem_mmio_responder_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_wren;
  logic [DATA_W-1:0] cpu_q;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  cpu_address, cpu_data, cpu_wren, mem_q, out_ready,
    output cpu_q, mem_address, mem_data, mem_wren, out_data, out_valid
  );

  modport master (
    output cpu_address, cpu_data, cpu_wren, mem_q, out_ready,
    input  cpu_q, mem_address, mem_data, mem_wren, out_data, out_valid
  );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder: passes traffic through to dmem and serves a 256-word MMIO
// window (TX FIFO, cycle counter, drop counter) with the same one-cycle read latency as dmem.
module dmem_mmio_responder #(
  parameter int              ADDR_W     = 12,
  parameter int              DATA_W     = 32,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 12'hF00,
  parameter int              FIFO_DEPTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  dmem_mmio_responder_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              is_mmio;
  logic [7:0]        offset;
  logic              hit_tx, hit_cyc, hit_drops;
  logic              push, pop, push_ok, drop;
  logic              full, empty;

  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] cycles_q, cycles_d;
  logic [DATA_W-1:0] drops_q, drops_d;
  logic              sel_mmio_q, sel_mmio_d;
  logic [DATA_W-1:0] mmio_rd_q, mmio_rd_d;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];

  assign is_mmio   = (bus.cpu_address[ADDR_W-1:8] == MMIO_BASE[ADDR_W-1:8]);
  assign offset    = bus.cpu_address[7:0];
  assign hit_tx    = is_mmio && (offset == 8'h00);
  assign hit_cyc   = is_mmio && (offset == 8'h02);
  assign hit_drops = is_mmio && (offset == 8'h03);

  assign bus.mem_address = bus.cpu_address;
  assign bus.mem_data    = bus.cpu_data;
  assign bus.mem_wren    = bus.cpu_wren & ~is_mmio;

  assign full          = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty         = (count_q == '0);
  assign bus.out_valid = ~empty;
  assign bus.out_data  = fifo_q[rd_ptr_q];
  assign bus.cpu_q     = sel_mmio_q ? mmio_rd_q : bus.mem_q;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign pop     = bus.out_valid & bus.out_ready;
  assign push    = bus.cpu_wren & hit_tx;
  assign push_ok = push & (~full | pop);
  assign drop    = push & ~push_ok;

  always_comb begin
    status          = '0;
    status[0]       = full;
    status[1]       = empty;
    status[4 +: CNT_W] = count_q;
  end

  always_comb begin
    count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    cycles_d   = (bus.cpu_wren && hit_cyc) ? bus.cpu_data : cycles_q + 1'b1;
    drops_d    = drops_q;
    if (bus.cpu_wren && hit_drops) begin
      drops_d = '0;
    end else if (drop && (drops_q != '1)) begin
      drops_d = drops_q + 1'b1;
    end
    sel_mmio_d = is_mmio;
    mmio_rd_d  = '0;
    if (is_mmio) begin
      case (offset)
        8'h01:   mmio_rd_d = status;
        8'h02:   mmio_rd_d = cycles_q;
        8'h03:   mmio_rd_d = drops_q;
        default: mmio_rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cycles_q   <= '0;
      drops_q    <= '0;
      sel_mmio_q <= 1'b0;
      mmio_rd_q  <= '0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cycles_q   <= cycles_d;
      drops_q    <= drops_d;
      sel_mmio_q <= sel_mmio_d;
      mmio_rd_q  <= mmio_rd_d;
    end
  end

  // Storage is not reset; the cleared count makes stale entries unreachable.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= bus.cpu_data;
    end
  end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: directed vector table, reset sequence, then random traffic
// checked against a queue-based model of the MMIO window and a shadow of dmem.
module tb_dmem_mmio_responder;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dmem_mmio_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_mmio_responder #(
    .ADDR_W(AW), .DATA_W(DW), .MMIO_BASE(12'hF00), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // dmem syncram: read-old-data, one cycle latency
  logic [DW-1:0] dmem [4096];
  always @(posedge clock) begin
    if (bus.mem_wren) dmem[bus.mem_address] <= bus.mem_data;
    bus.mem_q <= dmem[bus.mem_address];
  end

  logic [DW-1:0] fifo_m [$];
  logic [DW-1:0] dmem_m [int];
  logic [DW-1:0] cycles_m;
  logic [DW-1:0] drops_m;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          we;
    logic          rdy;
    logic          chk_q;
    logic [DW-1:0] exp_q;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
  } vec_t;
  vec_t vecs [$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] status_m();
    logic [DW-1:0] s;
    int n;
    n = fifo_m.size();
    s = '0;
    s[0] = (n == DEPTH);
    s[1] = (n == 0);
    s[8:4] = 5'(n);
    return s;
  endfunction

  // One clock: drive, check dmem write enable, advance model, check registered outputs.
  task automatic cycle(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we,
                       input logic rdy, input logic rst);
    logic          is_m;
    logic [7:0]    off;
    logic [DW-1:0] rd;
    logic          q_known;
    logic          push_req;
    bus.cpu_address = a;
    bus.cpu_data    = d;
    bus.cpu_wren    = we;
    bus.out_ready   = rdy;
    reset           = rst;
    is_m = (a[11:8] == 4'hF);
    off  = a[7:0];
    #1;
    check("mem_wren", {31'b0, bus.mem_wren}, {31'b0, we & ~is_m});
    q_known = 1'b1;
    rd      = '0;
    if (is_m) begin
      if (off == 8'h01) rd = status_m();
      else if (off == 8'h02) rd = cycles_m;
      else if (off == 8'h03) rd = drops_m;
      if (rst) q_known = 1'b0;
    end else if (dmem_m.exists(int'(a))) begin
      rd = dmem_m[int'(a)];
    end else begin
      q_known = 1'b0;
    end
    if (we && !is_m) dmem_m[int'(a)] = d;
    if (rst) begin
      fifo_m.delete();
      cycles_m = '0;
      drops_m  = '0;
    end else begin
      push_req = we && is_m && (off == 8'h00);
      if (rdy && fifo_m.size() != 0) void'(fifo_m.pop_front());
      if (push_req) begin
        if (fifo_m.size() < DEPTH) fifo_m.push_back(d);
        else if (!(we && is_m && off == 8'h03) && drops_m != 32'hFFFF_FFFF) drops_m = drops_m + 1;
      end
      cycles_m = (we && is_m && off == 8'h02) ? d : cycles_m + 1;
      if (we && is_m && off == 8'h03) drops_m = '0;
    end
    @(posedge clock);
    @(negedge clock);
    if (q_known) check("cpu_q", bus.cpu_q, rd);
    check("out_valid", {31'b0, bus.out_valid}, {31'b0, fifo_m.size() != 0});
    if (fifo_m.size() != 0) check("out_data", bus.out_data, fifo_m[0]);
  endtask

  task automatic add(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we,
                     input logic rdy, input logic chk_q, input logic [DW-1:0] exp_q,
                     input logic exp_valid, input logic [DW-1:0] exp_data);
    vec_t v;
    v.addr = a; v.data = d; v.we = we; v.rdy = rdy; v.chk_q = chk_q;
    v.exp_q = exp_q; v.exp_valid = exp_valid; v.exp_data = exp_data;
    vecs.push_back(v);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [7:0]    off;
    logic [DW-1:0] d;
    logic          we, rdy, rst;
    int            s;

    bus.cpu_address = '0;
    bus.cpu_data    = '0;
    bus.cpu_wren    = 1'b0;
    bus.out_ready   = 1'b0;
    reset           = 1'b1;
    fifo_m.delete();
    cycles_m = '0;
    drops_m  = '0;
    @(negedge clock);
    cycle(12'h010, '0, 1'b0, 1'b0, 1'b1);
    cycle(12'h010, '0, 1'b0, 1'b0, 1'b1);
    check("reset_valid", {31'b0, bus.out_valid}, 32'h0);

    // plain dmem write then read
    add(12'h010, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 0);
    add(12'h010, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
    // fill the FIFO, then one dropped push
    for (int i = 1; i <= 16; i++) add(12'hF00, DW'(i), 1, 0, 0, 0, 1, 1);
    add(12'hF01, 0, 0, 0, 1, 32'h101, 1, 1);
    add(12'hF00, 17, 1, 0, 0, 0, 1, 1);
    add(12'hF03, 0, 0, 0, 1, 1, 1, 1);
    // push and pop while full, then drain
    add(12'hF00, 32'hAA, 1, 1, 0, 0, 1, 2);
    for (int i = 0; i < 16; i++)
      add(12'h010, 0, 0, 1, 1, 32'hDEAD_BEEF, i < 15, (i < 14) ? DW'(i + 3) : 32'hAA);
    add(12'hF01, 0, 0, 0, 1, 32'h2, 0, 0);
    // push and pop on empty: the word is kept
    add(12'hF00, 32'h55, 1, 1, 0, 0, 1, 32'h55);
    add(12'h010, 0, 0, 1, 1, 32'hDEAD_BEEF, 0, 0);
    // cycle counter wrap, drop counter clear
    add(12'hF02, 32'hFFFF_FFFE, 1, 0, 0, 0, 0, 0);
    add(12'h010, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
    add(12'h010, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
    add(12'hF02, 0, 0, 0, 1, 0, 0, 0);
    add(12'hF03, 32'h5, 1, 0, 0, 0, 0, 0);
    add(12'hF03, 0, 0, 0, 1, 0, 0, 0);
    // unmapped MMIO word
    add(12'hF80, 32'h1234, 1, 0, 0, 0, 0, 0);
    add(12'hF80, 0, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].addr, vecs[i].data, vecs[i].we, vecs[i].rdy, 1'b0);
      if (vecs[i].chk_q) check($sformatf("tbl%0d_q", i), bus.cpu_q, vecs[i].exp_q);
      check($sformatf("tbl%0d_valid", i), {31'b0, bus.out_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) check($sformatf("tbl%0d_data", i), bus.out_data, vecs[i].exp_data);
    end
    check("dmem_f80_untouched", {31'b0, dmem[12'hF80] == 32'h1234}, 32'h0);

    // reset with queued entries and an MMIO read in flight
    for (int i = 0; i < 5; i++) cycle(12'hF00, DW'(32'h100 + i), 1'b1, 1'b0, 1'b0);
    cycle(12'hF02, '0, 1'b0, 1'b0, 1'b0);
    cycle(12'h010, '0, 1'b0, 1'b0, 1'b1);
    check("rst_valid", {31'b0, bus.out_valid}, 32'h0);
    check("rst_q", bus.cpu_q, 32'hDEAD_BEEF);
    cycle(12'hF02, '0, 1'b0, 1'b0, 1'b0);
    check("rst_cycles", bus.cpu_q, 32'h0);
    cycle(12'hF01, '0, 1'b0, 1'b0, 1'b0);
    check("rst_status", bus.cpu_q, 32'h2);

    for (int i = 0; i < 16; i++) cycle(AW'(i), $urandom, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      off = 8'hFF;
      if ($urandom_range(0, 9) < 4) begin
        a = AW'($urandom_range(0, 15));
      end else begin
        s = $urandom_range(0, 9);
        if (s < 4) off = 8'h00;
        else if (s < 6) off = 8'h01;
        else if (s == 6) off = 8'h02;
        else if (s == 7) off = 8'h03;
        else if (s == 8) off = 8'h04;
        else off = 8'($urandom_range(5, 255));
        a = 12'hF00 | AW'(off);
      end
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      if (off == 8'h02 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - DW'($urandom_range(0, 3));
      rdy = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      if (rst) we = 1'b0;
      cycle(a, d, we, rdy, rst);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
